path_delay_monitor: RTL and testbench

PATH_DELAY_MONITOR -- requirements
Module: path_delay_monitor

---
 rtl/path_delay_monitor.sv | 148 ++++++++++++++
 tb/tb_path_delay_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/path_delay_monitor.sv
// Path delay monitor: toggles a launch level into an external chain and measures, in clk cycles,
// how long the synchronized chain output takes to follow. Min/max tracking is built only with PATH_DELAY_MINMAX_EN.
module path_delay_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter bit          INVERT  = 1'b0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         trials,
  output logic               launch,
  input  logic               path_result,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [CNT_W+7:0]   sum_cycles,
  output logic [CNT_W-1:0]   min_cycles,
  output logic [CNT_W-1:0]   max_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A TIMEOUT beyond the counter range is clamped so the saturated counter still reaches it.
  localparam logic [CNT_W-1:0] TIMEOUT_CNT =
    (CNT_W < 32 && TIMEOUT >= (32'd1 << CNT_W)) ? CNT_MAX : CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, DONE} stateType;

  stateType         state, stateNext;
  logic             syncMeta, resS;
  logic             launchReg, expected, timeoutReg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       settleCnt;
  logic [8:0]       trialsLeft;
  logic [CNT_W+7:0] sumReg;
  logic             resMatch;

  assign resMatch = (resS == expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta <= 1'b0;
      resS     <= 1'b0;
    end else begin
      syncMeta <= path_result;
      resS     <= syncMeta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) stateNext = LAUNCH;
      end
      LAUNCH: stateNext = WAIT;
      WAIT: begin
        if (resMatch)                stateNext = SETTLE;
        else if (cnt == TIMEOUT_CNT) stateNext = DONE;
      end
      SETTLE: begin
        if (settleCnt == 2'd3) stateNext = (trialsLeft == 9'd0) ? DONE : LAUNCH;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launchReg  <= 1'b0;
      expected   <= 1'b0;
      timeoutReg <= 1'b0;
      cnt        <= '0;
      settleCnt  <= 2'd0;
      trialsLeft <= 9'd0;
      sumReg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            trialsLeft <= (trials == 8'd0) ? 9'd256 : {1'b0, trials};
            sumReg     <= '0;
            timeoutReg <= 1'b0;
          end
        end
        LAUNCH: begin
          launchReg <= ~launchReg;
          expected  <= ~launchReg ^ INVERT;
          cnt       <= '0;
        end
        WAIT: begin
          // The count recorded is the cnt value in the cycle the match is seen.
          if (resMatch) begin
            sumReg     <= sumReg + {8'd0, cnt};
            trialsLeft <= trialsLeft - 9'd1;
            settleCnt  <= 2'd0;
          end else if (cnt == TIMEOUT_CNT) begin
            timeoutReg <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SETTLE: settleCnt <= settleCnt + 2'd1;
        default: ;
      endcase
    end
  end

  assign launch      = launchReg;
  assign timeout_err = timeoutReg;
  assign sum_cycles  = sumReg;

`ifdef PATH_DELAY_MINMAX_EN
  logic [CNT_W-1:0] minReg, maxReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minReg <= '1;
      maxReg <= '0;
    end else if (state == IDLE && start) begin
      minReg <= '1;
      maxReg <= '0;
    end else if (state == WAIT && resMatch) begin
      if (cnt < minReg) minReg <= cnt;
      if (cnt > maxReg) maxReg <= cnt;
    end
  end

  assign min_cycles = minReg;
  assign max_cycles = maxReg;
`else
  assign min_cycles = '0;
  assign max_cycles = '0;
`endif

endmodule

// File: tb/tb_path_delay_monitor.sv
// Bench for path_delay_monitor: a chain model with a per-launch delay, a table of directed
// measurements, randomized measurements against a count model, and reset / held-start sequences.
module tb_path_delay_monitor;
  localparam int CNT_W = 16;
  localparam int TMO   = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         trials = 8'd0;
  logic               launch;
  logic               path_result;
  logic               busy, done, timeout_err;
  logic [CNT_W+7:0]   sum_cycles;
  logic [CNT_W-1:0]   min_cycles, max_cycles;

  int checks = 0;
  int errors = 0;

  path_delay_monitor #(.CNT_W(CNT_W), .INVERT(1'b0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .trials(trials), .launch(launch),
    .path_result(path_result), .busy(busy), .done(done), .timeout_err(timeout_err),
    .sum_cycles(sum_cycles), .min_cycles(min_cycles), .max_cycles(max_cycles)
  );

  always #5 clk = ~clk;

  // Chain model: the k-th launch toggle appears on pr delayArr[k] edges after launch changed.
  logic [3:0] delayArr [256];
  int   toggles = 0;
  int   pend = 0;
  logic lastL = 1'b0, pendVal = 1'b0, pr = 1'b0;
  bit   stuck = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lastL <= 1'b0; pr <= 1'b0; pend <= 0; pendVal <= 1'b0;
    end else begin
      lastL <= launch;
      if (launch != lastL) begin
        toggles <= toggles + 1;
        if (delayArr[toggles[7:0]] <= 4'd1) pr <= launch;
        else begin
          pend    <= int'(delayArr[toggles[7:0]]) - 1;
          pendVal <= launch;
        end
      end else if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) pr <= pendVal;
      end
    end
  end
  assign path_result = stuck ? 1'b0 : pr;

  int doneCnt = 0;
  always @(negedge clk) if (done) doneCnt <= doneCnt + 1;

  bit launchExp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int mm(input int v);
`ifdef PATH_DELAY_MINMAX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic checkReset(input string tag);
    check({tag, "_launch"}, 64'(launch), 64'(0));
    check({tag, "_busy"},   64'(busy), 64'(0));
    check({tag, "_done"},   64'(done), 64'(0));
    check({tag, "_tmo"},    64'(timeout_err), 64'(0));
    check({tag, "_sum"},    64'(sum_cycles), 64'(0));
    check({tag, "_min"},    64'(min_cycles), 64'(mm(65535)));
    check({tag, "_max"},    64'(max_cycles), 64'(0));
  endtask

  // Called at a negedge; runs one measurement and checks its results, leaving the DUT idle.
  task automatic runMeas(input string tag, input logic [7:0] tr, input bit hold,
                         input int eSum, input int eMin, input int eMax, input bit eTo,
                         input int eTog, input int eLat);
    int cyc;
    int tog0, done0;
    tog0  = toggles;
    done0 = doneCnt;
    trials = tr;
    start  = 1'b1;
    @(negedge clk);
    check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    if (!hold) start = 1'b0;
    cyc = 1;
    while (!done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    check({tag, "_latency"}, 64'(cyc - 1), 64'(eLat));
    check({tag, "_sum"}, 64'(sum_cycles), 64'(eSum));
    check({tag, "_min"}, 64'(min_cycles), 64'(mm(eMin)));
    check({tag, "_max"}, 64'(max_cycles), 64'(mm(eMax)));
    check({tag, "_tmo"}, 64'(timeout_err), 64'(eTo));
    stuck = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after_done"}, 64'({busy, done}), 64'(0));
    start = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_still_idle"}, 64'(busy), 64'(0));
    check({tag, "_done_pulses"}, 64'(doneCnt - done0), 64'(1));
    check({tag, "_toggles"}, 64'(toggles - tog0), 64'(eTog));
    launchExp ^= eTog[0];
    check({tag, "_launch_level"}, 64'(launch), 64'(launchExp));
    $display("meas %s trials=%0d sum=%0d min=%0d max=%0d tmo=%0d latency=%0d",
             tag, tr, sum_cycles, min_cycles, max_cycles, timeout_err, cyc - 1);
  endtask

  typedef struct packed {
    logic [7:0]  tr;
    logic [3:0]  d0, d1, d2, d3;
    logic        stuck;
    logic        hold;
    logic [31:0] eSum, eMin, eMax;
    logic        eTo;
    logic [31:0] eTog, eLat;
  } vecT;

  vecT vecs [4];

  function automatic logic [3:0] pickD(input vecT v, input int i);
    case (i % 4)
      0: return v.d0;
      1: return v.d1;
      2: return v.d2;
      default: return v.d3;
    endcase
  endfunction

  initial begin
    int base, n, d, c, sum, mn, mx, lat, w, tog0, done0;
    string tag;
    for (int i = 0; i < 256; i++) delayArr[i] = 4'd1;
    // Measured count per trial is chain delay + 2 synchronizer cycles; each trial costs count+6 cycles.
    vecs[0] = '{8'd2, 4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 32'd0,   32'd65535, 32'd0, 1'b1, 32'd1,   32'd17};
    vecs[1] = '{8'd1, 4'd3, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1, 32'd5,   32'd5,     32'd5, 1'b0, 32'd1,   32'd11};
    vecs[2] = '{8'd4, 4'd2, 4'd6, 4'd3, 4'd4, 1'b0, 1'b0, 32'd23,  32'd4,     32'd8, 1'b0, 32'd4,   32'd47};
    vecs[3] = '{8'd0, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 32'd768, 32'd3,     32'd3, 1'b0, 32'd256, 32'd2304};

    #1;
    checkReset("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      base = toggles;
      n = (vecs[v].tr == 8'd0) ? 256 : int'(vecs[v].tr);
      for (int i = 0; i < n; i++) delayArr[(base + i) & 255] = pickD(vecs[v], i);
      stuck = vecs[v].stuck;
      tag = $sformatf("vec%0d", v);
      runMeas(tag, vecs[v].tr, vecs[v].hold, int'(vecs[v].eSum), int'(vecs[v].eMin),
              int'(vecs[v].eMax), vecs[v].eTo, int'(vecs[v].eTog), int'(vecs[v].eLat));
    end

    for (int r = 0; r < 8; r++) begin
      base = toggles;
      n = $urandom_range(1, 6);
      sum = 0; mn = 65535; mx = 0; lat = 0;
      for (int i = 0; i < n; i++) begin
        d = $urandom_range(1, 8);
        delayArr[(base + i) & 255] = 4'(d);
        c = d + 2;
        sum += c;
        if (c < mn) mn = c;
        if (c > mx) mx = c;
        lat += c + 6;
      end
      tag = $sformatf("rand%0d", r);
      runMeas(tag, 8'(n), bit'($urandom_range(0, 1)), sum, mn, mx, 1'b0, n, lat);
    end

    // Reset during the second trial's WAIT.
    base = toggles;
    for (int i = 0; i < 3; i++) delayArr[(base + i) & 255] = 4'd2;
    tog0 = toggles;
    trials = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (toggles - tog0 < 2 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("midrst_second_launch", 64'(toggles - tog0), 64'(2));
    check("midrst_sum_before", 64'(sum_cycles), 64'(4));
    done0 = doneCnt;
    #2 rst = 1'b1;
    #1;
    checkReset("midrst");
    @(negedge clk);
    @(negedge clk);
    check("midrst_no_done", 64'(doneCnt - done0), 64'(0));
    $display("meas midrst aborted by reset sum=%0d busy=%0d", sum_cycles, busy);
    rst = 1'b0;
    launchExp = 1'b0;
    delayArr[toggles & 255] = 4'd5;
    runMeas("after_rst", 8'd1, 1'b0, 7, 7, 7, 1'b0, 1, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
